// File: rtl/wb_memtest_if.sv
// Pipelined Wishbone B4 bus between the memory tester (master) and the memory under test (slave).
// Member names carry the master's point of view (o_ = driven by master, i_ = returned by slave).
interface wb_memtest_if #(
  parameter int unsigned AW = 19
);
  logic          o_wb_cyc;
  logic          o_wb_stb;
  logic          o_wb_we;
  logic [AW-1:0] o_wb_addr;
  logic [31:0]   o_wb_data;
  logic [3:0]    o_wb_sel;
  logic          i_wb_ack;
  logic          i_wb_stall;
  logic [31:0]   i_wb_data;

  modport master (
    output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel,
    input  i_wb_ack, i_wb_stall, i_wb_data
  );

  modport slave (
    input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel,
    output i_wb_ack, i_wb_stall, i_wb_data
  );
endinterface

// File: rtl/wb_memtest.sv
// Wishbone memory tester: writes words 0..LAST_ADDR, then reads them back and counts mismatches/timeouts.
// Define MEMTEST_LFSR_EN to use a seeded 32-bit Galois LFSR as the data pattern instead of the address.
module wb_memtest #(
  parameter int unsigned   AW        = 19,
  parameter logic [AW-1:0] LAST_ADDR = {AW{1'b1}},
  parameter int unsigned   GAP       = 2047,
  parameter int unsigned   TIMEOUT   = 255,
  parameter logic [31:0]   SEED      = 32'h1
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_start,
  wb_memtest_if.master  wb,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_pass,
  output logic [15:0]   o_err_count,
  output logic [AW-1:0] o_err_addr,
  output logic [31:0]   o_err_data,
  output logic [7:0]    o_diag
);

  typedef enum logic [2:0] {
    IDLE, WR_REQ, WR_WAIT, GAP_WAIT, RD_REQ, RD_WAIT, DONE
  } state_t;

  localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          cyc_q, cyc_d;
  logic          stb_q, stb_d;
  logic          we_q, we_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;
  logic [15:0]   err_count_q, err_count_d;
  logic [AW-1:0] err_addr_q, err_addr_d;
  logic [31:0]   err_data_q, err_data_d;
  logic [7:0]    diag_q, diag_d;
  logic [31:0]   gap_cnt_q, gap_cnt_d;
  logic [31:0]   to_cnt_q, to_cnt_d;
  logic [31:0]   pattern;

  logic ack_ok, timed_out, xfer_end, xfer_err;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

`ifdef MEMTEST_LFSR_EN
  localparam logic [31:0] LFSR_TAPS = 32'h80200003;
  logic [31:0] lfsr_q, lfsr_d;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h0);
  endfunction

  assign pattern = lfsr_q;
`else
  assign pattern = 32'(addr_q);
`endif

  // An ack only counts while the bus is owned and the request is not being stalled.
  assign ack_ok    = cyc_q && wb.i_wb_ack && !(stb_q && wb.i_wb_stall);
  assign timed_out = cyc_q && !ack_ok && (to_cnt_q == TO_LAST);
  assign xfer_end  = ack_ok || timed_out;
  assign xfer_err  = timed_out || (ack_ok && !we_q && (wb.i_wb_data != pattern));

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cyc_d       = cyc_q;
    stb_d       = stb_q;
    we_d        = we_q;
    done_d      = done_q;
    pass_d      = pass_q;
    err_count_d = err_count_q;
    err_addr_d  = err_addr_q;
    err_data_d  = err_data_q;
    diag_d      = diag_q;
    gap_cnt_d   = gap_cnt_q;
    to_cnt_d    = cyc_q ? to_cnt_q + 32'd1 : 32'd0;
`ifdef MEMTEST_LFSR_EN
    lfsr_d      = lfsr_q;
`endif

    if (xfer_err) begin
      err_count_d = sat_inc16(err_count_q);
      if (err_count_q == 16'h0) begin
        err_addr_d = addr_q;
        err_data_d = timed_out ? 32'h0 : wb.i_wb_data;
      end
    end
    if (ack_ok && !we_q) begin
      diag_d = wb.i_wb_data[18:11];
    end

    case (state_q)
      IDLE, DONE: begin
        if (i_start) begin
          state_d     = WR_REQ;
          addr_d      = '0;
          cyc_d       = 1'b1;
          stb_d       = 1'b1;
          we_d        = 1'b1;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          err_count_d = 16'h0;
          err_addr_d  = '0;
          err_data_d  = 32'h0;
`ifdef MEMTEST_LFSR_EN
          lfsr_d      = SEED;
`endif
        end
      end
      WR_REQ, RD_REQ: begin
        // cyc is low here only for the one idle cycle that separates back-to-back writes.
        if (!cyc_q) begin
          cyc_d = 1'b1;
          stb_d = 1'b1;
        end else if (!wb.i_wb_stall) begin
          stb_d   = 1'b0;
          state_d = (state_q == WR_REQ) ? WR_WAIT : RD_WAIT;
        end
      end
      GAP_WAIT: begin
        if (gap_cnt_q + 32'd1 >= GAP) begin
          state_d   = RD_REQ;
          cyc_d     = 1'b1;
          stb_d     = 1'b1;
          gap_cnt_d = 32'd0;
        end else begin
          gap_cnt_d = gap_cnt_q + 32'd1;
        end
      end
      default: ;
    endcase

    // Completion (ack or timeout) overrides whatever the state decoded above.
    if (xfer_end) begin
      cyc_d = 1'b0;
      stb_d = 1'b0;
`ifdef MEMTEST_LFSR_EN
      lfsr_d = lfsr_step(lfsr_q);
`endif
      if (we_q) begin
        if (addr_q == LAST_ADDR) begin
          addr_d    = '0;
          we_d      = 1'b0;
          gap_cnt_d = 32'd0;
          state_d   = GAP_WAIT;
`ifdef MEMTEST_LFSR_EN
          lfsr_d    = SEED;
`endif
        end else begin
          addr_d  = addr_q + AW'(1);
          state_d = WR_REQ;
        end
      end else if (addr_q == LAST_ADDR) begin
        state_d = DONE;
        done_d  = 1'b1;
        pass_d  = (err_count_d == 16'h0);
      end else begin
        addr_d    = addr_q + AW'(1);
        gap_cnt_d = 32'd0;
        state_d   = GAP_WAIT;
      end
    end

    busy_d = (state_d != IDLE) && (state_d != DONE);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_count_q <= 16'h0;
      err_addr_q  <= '0;
      err_data_q  <= 32'h0;
      diag_q      <= 8'h0;
      gap_cnt_q   <= 32'd0;
      to_cnt_q    <= 32'd0;
`ifdef MEMTEST_LFSR_EN
      lfsr_q      <= 32'h0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      we_q        <= we_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_count_q <= err_count_d;
      err_addr_q  <= err_addr_d;
      err_data_q  <= err_data_d;
      diag_q      <= diag_d;
      gap_cnt_q   <= gap_cnt_d;
      to_cnt_q    <= to_cnt_d;
`ifdef MEMTEST_LFSR_EN
      lfsr_q      <= lfsr_d;
`endif
    end
  end

  assign wb.o_wb_cyc  = cyc_q;
  assign wb.o_wb_stb  = stb_q;
  assign wb.o_wb_we   = we_q;
  assign wb.o_wb_addr = addr_q;
  assign wb.o_wb_data = pattern;
  assign wb.o_wb_sel  = 4'hF;

  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_pass      = pass_q;
  assign o_err_count = err_count_q;
  assign o_err_addr  = err_addr_q;
  assign o_err_data  = err_data_q;
  assign o_diag      = diag_q;

endmodule

// File: doc/wb_memtest.md
WB_MEMTEST -- requirements
Module: wb_memtest

Interface
REQ-001 Parameter AW, default 19: Wishbone word-address width.
REQ-002 Parameter LAST_ADDR, default 2^AW-1: final word address tested; first is always 0.
REQ-003 Parameter GAP, default 2047: idle cycles between read transactions (0 = none).
REQ-004 Parameter TIMEOUT, default 255: cycles to wait for ack before abandoning a transaction.
REQ-005 Parameter SEED, default 32'h1: LFSR seed (used only with MEMTEST_LFSR_EN).
REQ-006 i_clk  in  1  single clock; all logic on rising edge.
REQ-007 i_reset  in  1  asynchronous, active-high reset.
REQ-008 i_start  in  1  one-cycle pulse begins a write-then-read test.
REQ-009 o_wb_cyc, o_wb_stb, o_wb_we  out  1 each  pipelined Wishbone master controls.
REQ-010 o_wb_addr  out  AW  word address; o_wb_data  out  32  write data; o_wb_sel  out  4  byte enables.
REQ-011 i_wb_ack, i_wb_stall  in  1 each; i_wb_data  in  32  read data.
REQ-012 o_busy, o_done, o_pass  out  1 each  status.
REQ-013 o_err_count  out  16  saturating mismatch+timeout count.
REQ-014 o_err_addr  out  AW, o_err_data  out  32  address and read data of first failure.
REQ-015 o_diag  out  8  read data bits [18:11] of last completed read.

Function
REQ-016 States: IDLE, WR_REQ, WR_WAIT, GAP_WAIT, RD_REQ, RD_WAIT, DONE.
REQ-017 IDLE/DONE + i_start -> WR_REQ, address 0, clear err_count/err_addr/err_data/o_pass/o_done; i_start ignored in all other states.
REQ-018 Exactly one outstanding transaction; o_wb_sel = 4'hF always.
REQ-019 *_REQ: cyc=stb=1; stb drops the cycle after stall is sampled low; -> *_WAIT.
REQ-020 Ack sampled in REQ state with stall low completes the transaction that same cycle (cyc drops next cycle).
REQ-021 *_WAIT: cyc=1, stb=0 until ack; cyc drops next cycle.
REQ-022 Write completion: address < LAST_ADDR -> address+1, WR_REQ; address = LAST_ADDR -> address 0, GAP_WAIT.
REQ-023 Read completion: compare i_wb_data with expected; mismatch increments err_count (saturates at 16'hFFFF) and, if first failure, latches address and data.
REQ-024 Read completion: address < LAST_ADDR -> address+1, GAP_WAIT; else DONE.
REQ-025 GAP_WAIT holds GAP cycles with cyc=0, then -> RD_REQ; GAP=0 gives RD_REQ next cycle.
REQ-026 Timeout: counter starts at cyc rise; reaching TIMEOUT with no ack drops cyc/stb, counts one error (latched as first failure with data 32'h0 if first), treated as completion.
REQ-027 Ack seen while cyc=0 is ignored.
REQ-028 DONE: o_done=1, o_busy=0, o_pass=(err_count==0); held until next i_start.
REQ-029 o_busy=1 in every state except IDLE and DONE.
REQ-030 Default expected/write data = zero-extended word address.

Reset
REQ-031 i_reset asynchronously forces IDLE; cyc, stb, we, busy, done, pass = 0; addr, data, err_count, err_addr, err_data, diag, counters = 0.
REQ-032 Reset mid-transaction drops cyc/stb immediately without waiting for ack.

Configuration
REQ-033 Macro MEMTEST_LFSR_EN: when defined, data = 32-bit Galois LFSR (taps 32'h80200003), loaded with SEED at write start and again at read start, advanced once per completed transaction.
REQ-034 Without MEMTEST_LFSR_EN: address-as-data per REQ-030; no LFSR logic synthesized.

Verification
REQ-035 LAST_ADDR=7, GAP=0, zero-wait slave, i_start -> 8 writes data 0..7, 8 reads, o_done=1, o_pass=1, o_err_count=0.
REQ-036 Slave returns 32'h5 at addr 3 on read -> o_err_count=1, o_err_addr=3, o_err_data=32'h5, o_pass=0.
REQ-037 Stall held 3 cycles each request -> stb stays high exactly 4 cycles, one transaction per address, pass.
REQ-038 Slave never acks addr 2, TIMEOUT=15 -> cyc drops 15 cycles after rising, err_count=1, err_addr=2, test still reaches DONE.
REQ-039 i_reset asserted during RD_WAIT -> cyc=0 same cycle, all outputs zero; later i_start reruns cleanly.
REQ-040 MEMTEST_LFSR_EN, SEED=1 -> write data sequence 1, 32'h80200003, ... and read-back compare passes.
